inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC00000, SHALL set the first fetch PC after reset.
REQ-002 Parameter QUEUE_DEPTH, default 4, SHALL set the number of fetch-group entries in the queue.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 ibus_read  output  1  fetch request valid.
REQ-006 ibus_address  output  32  fetch-group address; bits [2:0] always zero.
REQ-007 ibus_stall  input  1  request not accepted this cycle.
REQ-008 ibus_valid  input  1  one-cycle pulse carrying response data.
REQ-009 ibus_rddata  input  64  two instructions: [31:0] at address+0, [63:32] at address+4.
REQ-010 redirect_valid  input  1  flush request and new-PC load.
REQ-011 redirect_pc  input  32  new PC; bits [1:0] ignored and treated as zero.
REQ-012 out_valid  output  1  instruction available to decode.
REQ-013 out_ready  input  1  decode consumes the instruction.
REQ-014 out_inst  output  32  instruction word.
REQ-015 out_pc  output  32  PC of out_inst.

Function
REQ-016 A request SHALL be accepted on a cycle with ibus_read=1 and ibus_stall=0; while stalled, ibus_address SHALL hold its value and ibus_read SHALL stay high.
REQ-017 At most one accepted request SHALL be outstanding; its response SHALL be the next ibus_valid pulse, arriving at least 1 cycle after acceptance.
REQ-018 Requests SHALL issue only when occupied entries plus outstanding requests are fewer than QUEUE_DEPTH.
REQ-019 The FSM SHALL have states IDLE, REQ, WAIT, DROP_REQ and DROP_WAIT.
REQ-020 IDLE->REQ when the issue condition holds; REQ->WAIT on acceptance; WAIT->IDLE or REQ on ibus_valid, with the response pushed.
REQ-021 On acceptance of fetch PC p, the PC SHALL become (p & ~7) + 8; the wrap from 32'hFFFFFFF8 to 0 is silent.
REQ-022 A pushed entry SHALL hold {group address, rddata, mask}; mask = 2'b10 if p[2]=1, else 2'b11.
REQ-023 out_valid SHALL be high when the queue is non-empty; it presents the lowest masked-in word; a pop clears that mask bit; the entry retires when the mask reaches 0.
REQ-024 The pop path SHALL sustain one instruction per cycle; a push and a pop in the same cycle are both honoured.
REQ-025 Push-to-out_valid latency: the cycle after ibus_valid (empty queue).
REQ-026 Redirect SHALL flush the queue, drop any pop in that cycle, and load the PC from redirect_pc; out_valid=0 the next cycle.
REQ-027 Redirect in IDLE SHALL go to REQ (issue condition now true).
REQ-028 Redirect in REQ: if accepted that cycle, go to DROP_WAIT; if stalled, go to DROP_REQ and keep presenting the stale address until accepted, then go to DROP_WAIT.
REQ-029 Redirect in WAIT without ibus_valid SHALL go to DROP_WAIT; with ibus_valid in the same cycle, the data SHALL be discarded and the FSM SHALL go to REQ.
REQ-030 DROP_WAIT SHALL discard the next ibus_valid, then go to REQ with the new PC.
REQ-031 A redirect in a DROP state SHALL only update the PC; the state is unchanged.

Reset
REQ-032 While rst=1: PC=RESET_PC, queue empty, state IDLE, ibus_read=0, ibus_address=0, out_valid=0, out_inst=0, out_pc=0.
REQ-033 Reset mid-request SHALL abandon the request; the bus slave is reset by the same rst.
REQ-034 First request: ibus_read=1 with address RESET_PC on the first cycle after rst falls.

Structure
REQ-035 The shared CPU package SHALL hold fetch_entry_t {addr[31:0], data[63:0], mask[1:0]}, RESET_PC_DEFAULT, and FETCH_QUEUE_DEPTH.
REQ-036 The queue SHALL be the sub-module fetch_queue (circular buffer with push, pop-word, flush, count); the FSM and PC stay in inst_fetch.
REQ-037 Size target: 120-400 lines of RTL in total.

Verification
REQ-038 Reset release, memory returns data = address, out_ready=1 -> out_pc sequence BFC00000, BFC00004, BFC00008…, out_inst = out_pc.
REQ-039 Redirect to 13579BD4 while in WAIT -> stale response dropped; next ibus_address 13579BD0; first out_pc 13579BD4 (mask 2'b10).
REQ-040 out_ready=0 with zero-latency responses -> exactly 4 requests accepted, then ibus_read=0; out_ready=1 -> requests resume.
REQ-041 ibus_stall=1 for 5 cycles with a redirect on cycle 2 -> address stable for all 5 cycles; stale response discarded; next request at redirect target.
REQ-042 Redirect coincident with ibus_valid and out_ready -> no instruction popped or pushed; next cycle out_valid=0 and ibus_read=1 at the new PC.
REQ-043 rst asserted during DROP_WAIT -> all outputs at reset values next cycle; fetch restarts at BFC00000.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared CPU fetch types, defaults and address helper
package inst_fetch_pkg;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam int FETCH_QUEUE_DEPTH = 4;
    typedef struct packed {
        logic [31:0] addr;
        logic [63:0] data;
        logic [1:0]  mask;
    } fetch_entry_t;
    function automatic logic [31:0] group_addr(input logic [31:0] pc);
        return pc & ~32'd7;
    endfunction
endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: instruction bus, redirect and decode-side handshake of the fetch unit
interface inst_fetch_if;
    logic        ibus_read;
    logic [31:0] ibus_address;
    logic        ibus_stall;
    logic        ibus_valid;
    logic [63:0] ibus_rddata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    modport master (
        output ibus_read, ibus_address, out_valid, out_inst, out_pc,
        input  ibus_stall, ibus_valid, ibus_rddata, redirect_valid, redirect_pc, out_ready
    );
    modport slave (
        input  ibus_read, ibus_address, out_valid, out_inst, out_pc,
        output ibus_stall, ibus_valid, ibus_rddata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of fetch groups, popped one instruction word at a time
module fetch_queue
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_QUEUE_DEPTH,
    parameter int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_entry,
    input  logic          pop,
    output logic          valid,
    output logic [31:0]   word,
    output logic [31:0]   pc,
    output logic [CW-1:0] count
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    fetch_entry_t mem_q [DEPTH];
    fetch_entry_t head;
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0] mask_d;
    logic push_en, pop_en, retire;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        head = mem_q[head_q];
        valid = count_q != '0;
        push_en = push && !flush;
        pop_en = pop && valid && !flush;
        mask_d = head.mask[0] ? {head.mask[1], 1'b0} : 2'b00;
        retire = pop_en && mask_d == 2'b00;
        word = !valid ? '0 : head.mask[0] ? head.data[31:0] : head.data[63:32];
        pc = !valid ? '0 : head.mask[0] ? head.addr : head.addr + 32'd4;
        head_d = flush ? '0 : retire ? next_ptr(head_q) : head_q;
        tail_d = flush ? '0 : push_en ? next_ptr(tail_q) : tail_q;
        count_d = flush ? '0 : count_q + CW'(push_en) - CW'(retire);
        count = count_q;
    end

    // A push and a pop never hit the same slot: that needs an empty or a full queue
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
        end
        if (push_en) mem_q[tail_q] <= push_entry;
        if (pop_en) mem_q[head_q].mask <= mask_d;
    end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC sequencing and fetch FSM feeding a queue of two-instruction groups
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int QUEUE_DEPTH = FETCH_QUEUE_DEPTH
) (
    input logic clk,
    input logic rst,
    inst_fetch_if.master bus
);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] DROP_REQ = 3'd3;
    localparam logic [2:0] DROP_WAIT = 3'd4;

    logic [2:0] state_q, state_d;
    logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d, drop_addr_q, drop_addr_d;
    logic [CW-1:0] count;
    logic redir, acc, push, pop, room_idle, room_push;
    fetch_entry_t push_entry;

    always_comb begin
        redir = bus.redirect_valid;
        bus.ibus_read = state_q == REQ || state_q == DROP_REQ;
        bus.ibus_address = state_q == REQ ? group_addr(pc_q) : state_q == DROP_REQ ? drop_addr_q : '0;
        acc = (state_q == REQ || state_q == DROP_REQ) && !bus.ibus_stall;
        push = state_q == WAIT && bus.ibus_valid && !redir;
        pop = bus.out_ready && !redir;
        room_idle = 32'(count) < QUEUE_DEPTH;
        room_push = 32'(count) + 32'd1 < QUEUE_DEPTH;
        push_entry = '{addr: group_addr(req_pc_q), data: bus.ibus_rddata, mask: req_pc_q[2] ? 2'b10 : 2'b11};
        pc_d = redir ? bus.redirect_pc & ~32'd3 : state_q == REQ && acc ? group_addr(pc_q) + 32'd8 : pc_q;
        req_pc_d = state_q == REQ && acc ? pc_q : req_pc_q;
        // a stalled stale request must keep its address while the PC moves on
        drop_addr_d = state_q == REQ && redir ? group_addr(pc_q) : drop_addr_q;
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = redir || room_idle ? REQ : IDLE;
            REQ:       state_d = acc ? (redir ? DROP_WAIT : WAIT) : (redir ? DROP_REQ : REQ);
            WAIT:      state_d = redir ? (bus.ibus_valid ? REQ : DROP_WAIT)
                               : !bus.ibus_valid ? WAIT : room_push ? REQ : IDLE;
            DROP_REQ:  state_d = acc ? DROP_WAIT : DROP_REQ;
            DROP_WAIT: state_d = bus.ibus_valid ? REQ : DROP_WAIT;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q <= RESET_PC & ~32'd3;
            req_pc_q <= '0;
            drop_addr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            req_pc_q <= req_pc_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    fetch_queue #(.DEPTH(QUEUE_DEPTH), .CW(CW)) u_queue (
        .clk(clk),
        .rst(rst),
        .flush(redir),
        .push(push),
        .push_entry(push_entry),
        .pop(pop),
        .valid(bus.out_valid),
        .word(bus.out_inst),
        .pc(bus.out_pc),
        .count(count)
    );
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed checks of fetch sequencing, backpressure, redirects and reset
module tb_inst_fetch;
    logic clk = 1'b0;
    logic rst;
    int n_cmp = 0;
    int n_bad = 0;
    int lat = 0;
    int n_acc = 0;
    int wait_cnt = 0;
    logic pend = 1'b0;
    logic [31:0] pend_addr = '0;

    inst_fetch_if bus ();
    inst_fetch dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // memory slave: returns {addr+4, addr} lat cycles after the cycle following acceptance
    always @(posedge clk) begin
        bus.ibus_valid <= 1'b0;
        if (rst) begin
            pend = 1'b0;
            n_acc = 0;
        end else begin
            if (bus.ibus_read && !bus.ibus_stall) begin
                pend = 1'b1;
                pend_addr = bus.ibus_address;
                wait_cnt = lat;
                n_acc++;
            end
            if (pend) begin
                if (wait_cnt == 0) begin
                    bus.ibus_valid <= 1'b1;
                    bus.ibus_rddata <= {pend_addr + 32'd4, pend_addr};
                    pend = 1'b0;
                end else wait_cnt--;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = target;
        step(1);
        bus.redirect_valid = 1'b0;
    endtask

    task automatic wait_read();
        for (int i = 0; i < 30 && bus.ibus_read !== 1'b1; i++) step(1);
        check("wait_read", bus.ibus_read, 1);
    endtask

    task automatic expect_stream(input logic [31:0] first, input int n);
        for (int i = 0; i < 40 && bus.out_valid !== 1'b1; i++) step(1);
        for (int k = 0; k < n; k++) begin
            check("stream_valid", bus.out_valid, 1);
            check("stream_pc", bus.out_pc, first + 32'(4 * k));
            check("stream_inst", bus.out_inst, first + 32'(4 * k));
            step(1);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_read", bus.ibus_read, 0);
        check("rst_addr", bus.ibus_address, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_inst", bus.out_inst, 0);
        check("rst_out_pc", bus.out_pc, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.ibus_stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready = 1'b0;
        step(2);
        check_reset_outputs();
        // straight-line fetch with an always-ready decoder
        bus.out_ready = 1'b1;
        rst = 1'b0;
        step(1);
        check("first_read", bus.ibus_read, 1);
        check("first_addr", bus.ibus_address, 32'hBFC0_0000);
        expect_stream(32'hBFC0_0000, 19);
        // decoder stalled: queue fills after four groups
        bus.out_ready = 1'b0;
        do_reset();
        step(12);
        check("bp_accepts", n_acc, 4);
        check("bp_read", bus.ibus_read, 0);
        check("bp_head_pc", bus.out_pc, 32'hBFC0_0000);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_drain_pc", bus.out_pc, 32'hBFC0_0000 + 32'(4 * i));
            step(1);
        end
        check("bp_resume", n_acc, 5);
        // redirect while waiting on a slow response
        lat = 3;
        do_reset();
        step(2);
        check("w_wait_read", bus.ibus_read, 0);
        redirect(32'h1357_9BD6);
        check("w_drop_read", bus.ibus_read, 0);
        wait_read();
        check("w_new_addr", bus.ibus_address, 32'h1357_9BD0);
        check("w_no_stale", bus.out_valid, 0);
        expect_stream(32'h1357_9BD4, 1);
        // stalled request with a redirect on its second cycle
        lat = 0;
        bus.ibus_stall = 1'b1;
        do_reset();
        step(1);
        for (int c = 1; c <= 5; c++) begin
            check("s_read", bus.ibus_read, 1);
            check("s_addr", bus.ibus_address, 32'hBFC0_0000);
            bus.redirect_valid = (c == 2);
            bus.redirect_pc = 32'h2468_ACE0;
            step(1);
        end
        check("s_addr_held", bus.ibus_address, 32'hBFC0_0000);
        bus.ibus_stall = 1'b0;
        step(1);
        check("s_drop_wait", bus.ibus_read, 0);
        wait_read();
        check("s_new_addr", bus.ibus_address, 32'h2468_ACE0);
        check("s_no_stale", bus.out_valid, 0);
        expect_stream(32'h2468_ACE0, 4);
        // redirect coincident with a response and a pop
        do_reset();
        step(4);
        check("c_pre_valid", bus.out_valid, 1);
        check("c_pre_pc", bus.out_pc, 32'hBFC0_0004);
        redirect(32'h0000_1000);
        check("c_out_valid", bus.out_valid, 0);
        check("c_read", bus.ibus_read, 1);
        check("c_addr", bus.ibus_address, 32'h0000_1000);
        expect_stream(32'h0000_1000, 4);
        // redirect from IDLE to the top of memory: PC wraps to zero
        do_reset();
        redirect(32'hFFFF_FFFC);
        check("x_addr", bus.ibus_address, 32'hFFFF_FFF8);
        expect_stream(32'hFFFF_FFFC, 1);
        expect_stream(32'h0000_0000, 4);
        // reset while a dropped response is still outstanding
        lat = 5;
        do_reset();
        step(2);
        redirect(32'h5555_0000);
        check("r_drop_wait", bus.ibus_read, 0);
        rst = 1'b1;
        step(1);
        check_reset_outputs();
        rst = 1'b0;
        lat = 0;
        step(1);
        check("r_restart_read", bus.ibus_read, 1);
        check("r_restart_addr", bus.ibus_address, 32'hBFC0_0000);
        expect_stream(32'hBFC0_0000, 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
